// File: rtl/sim_jtag_scan_driver.sv
`default_nettype none
// ============================================================================
// sim_jtag_scan_driver: command-driven JTAG master that sequences TCK/TMS/TDI
// and returns the captured TDO vector.   Revision: 1.0
// ============================================================================
module sim_jtag_scan_driver #(
    parameter int TICK_DELAY = 50,
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               init_done,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_undriven,
    output logic               rsp_err,
    output logic               busy,
    output logic               jtag_TCK,
    output logic               jtag_TMS,
    output logic               jtag_TDI,
    output logic               jtag_TRSTn,
    input  logic               jtag_TDO_data,
    input  logic               jtag_TDO_driven
);

    localparam int CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] c_TICK_RELOAD = CNT_W'(TICK_DELAY);
    localparam logic [1:0]       c_OP_TAPRST   = 2'd0;
    localparam logic [1:0]       c_OP_IR       = 2'd1;
    localparam logic [1:0]       c_OP_DR       = 2'd2;
    localparam logic [1:0]       c_OP_IDLE     = 2'd3;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_IDLE  = 3'd1,
        S_HDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_TRL   = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t             state_q;
    logic               reset_dly_q;
    logic               init_sticky_q;
    logic               trstn_q;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic               phase_q;
    logic [LEN_W-1:0]   idx_q;
    logic [1:0]         op_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               rsp_valid_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               undriven_q;
    logic               err_q;

    logic               w_rst;
    logic               w_run;
    logic               w_tick;
    logic               w_accept;
    logic               w_scan_op;
    logic               w_len_bad;
    logic [IDX_W-1:0]   w_bit;
    logic [LEN_W-1:0]   w_last_idx;
    logic               w_tms;

    // The delayed copy stretches every reset by one clock.
    assign w_rst     = reset || reset_dly_q;
    assign w_run     = enable && init_sticky_q;
    assign w_tick    = w_run && (tick_cnt_q == '0);
    assign cmd_ready = !w_rst && (state_q == S_IDLE) && w_run && !rsp_valid_q;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_scan_op = (cmd_op == c_OP_IR) || (cmd_op == c_OP_DR);
    assign w_len_bad = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
    assign w_bit     = idx_q[IDX_W-1:0];
    assign busy      = !w_rst && (state_q != S_IDLE);

    always_ff @(posedge clock) begin
        reset_dly_q <= reset;
    end

    always_ff @(posedge clock) begin
        if (w_rst) begin
            init_sticky_q <= 1'b0;
            trstn_q       <= 1'b0;
            tick_cnt_q    <= c_TICK_RELOAD;
        end else begin
            if (init_done) begin
                init_sticky_q <= 1'b1;
            end
            if (init_sticky_q) begin
                trstn_q <= 1'b1;
            end
            if (w_tick) begin
                tick_cnt_q <= c_TICK_RELOAD;
            end else if (w_run) begin
                tick_cnt_q <= tick_cnt_q - CNT_W'(1);
            end
        end
    end

    // TMS value and final step index for the step in progress.
    always_comb begin
        w_last_idx = '0;
        w_tms      = 1'b0;
        case (state_q)
            S_BOOT: begin
                w_last_idx = LEN_W'(5);
                w_tms      = (idx_q < LEN_W'(5));
            end
            S_HDR: begin
                case (op_q)
                    c_OP_DR: begin
                        w_last_idx = LEN_W'(2);
                        w_tms      = (idx_q == '0);
                    end
                    c_OP_IR: begin
                        w_last_idx = LEN_W'(3);
                        w_tms      = (idx_q < LEN_W'(2));
                    end
                    c_OP_TAPRST: begin
                        w_last_idx = LEN_W'(5);
                        w_tms      = (idx_q < LEN_W'(5));
                    end
                    default: begin
                        w_last_idx = len_q - LEN_W'(1);
                        w_tms      = 1'b0;
                    end
                endcase
            end
            S_SHIFT: begin
                w_last_idx = len_q - LEN_W'(1);
                w_tms      = (idx_q == len_q - LEN_W'(1));
            end
            S_TRL: begin
                w_last_idx = LEN_W'(1);
                w_tms      = (idx_q == '0);
            end
            default: begin
                w_last_idx = '0;
                w_tms      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_rst) begin
            state_q     <= S_BOOT;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            op_q        <= c_OP_TAPRST;
            len_q       <= '0;
            data_q      <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            undriven_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        op_q       <= cmd_op;
                        len_q      <= cmd_len;
                        data_q     <= cmd_data;
                        idx_q      <= '0;
                        rsp_data_q <= '0;
                        undriven_q <= 1'b0;
                        if (w_scan_op && w_len_bad) begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end else if ((cmd_op == c_OP_IDLE) && (cmd_len == '0)) begin
                            err_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= S_HDR;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        undriven_q  <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (!phase_q) begin
                            tck_q   <= 1'b0;
                            tms_q   <= w_tms;
                            tdi_q   <= (state_q == S_SHIFT) ? data_q[w_bit] : 1'b0;
                            phase_q <= 1'b1;
                        end else begin
                            tck_q   <= 1'b1;
                            phase_q <= 1'b0;
                            if (state_q == S_SHIFT) begin
                                rsp_data_q[w_bit] <= jtag_TDO_driven && jtag_TDO_data;
                                if (!jtag_TDO_driven) begin
                                    undriven_q <= 1'b1;
                                end
                            end
                            if (idx_q == w_last_idx) begin
                                idx_q <= '0;
                                if (state_q == S_BOOT) begin
                                    state_q <= S_IDLE;
                                end else if (state_q == S_HDR) begin
                                    if ((op_q == c_OP_IR) || (op_q == c_OP_DR)) begin
                                        state_q <= S_SHIFT;
                                    end else begin
                                        rsp_valid_q <= 1'b1;
                                        state_q     <= S_RSP;
                                    end
                                end else if (state_q == S_SHIFT) begin
                                    state_q <= S_TRL;
                                end else begin
                                    rsp_valid_q <= 1'b1;
                                    state_q     <= S_RSP;
                                end
                            end else begin
                                idx_q <= idx_q + LEN_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_undriven = undriven_q;
    assign rsp_err      = err_q;
    assign jtag_TCK     = tck_q;
    assign jtag_TMS     = tms_q;
    assign jtag_TDI     = tdi_q;
    assign jtag_TRSTn   = trstn_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_jtag_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_sim_jtag_scan_driver: directed bench with a command-level JTAG pin model.
// Revision: 1.0
// ============================================================================
module tb_sim_jtag_scan_driver;

    localparam int TICK_DELAY = 1;
    localparam int MAX_LEN    = 64;
    localparam int LEN_W      = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic        und;
    } rsp_t;

    logic               clock     = 1'b0;
    logic               reset     = 1'b1;
    logic               enable    = 1'b1;
    logic               init_done = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op    = 2'd0;
    logic [LEN_W-1:0]   cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;
    logic               rsp_ready = 1'b1;
    logic               tdo_drv   = 1'b0;
    logic               lb_q      = 1'b0;
    logic               cmd_ready, rsp_valid, rsp_undriven, rsp_err, busy;
    logic [MAX_LEN-1:0] rsp_data;
    logic               jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edges   = 0;
    int          rsp_seen = 0;
    logic [63:0] tms_log = '0;
    logic [63:0] tdi_log = '0;
    bit          exp_tms_q[$];
    bit          exp_tdi_q[$];
    rsp_t        exp_rsp_q[$];
    rsp_t        cur_r;
    logic [63:0] last_data = '0;
    logic        last_err = 1'b0;
    logic        last_und = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] prev_data = '0;
    int          e0, e1;

    sim_jtag_scan_driver #(
        .TICK_DELAY(TICK_DELAY),
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .init_done      (init_done),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_len        (cmd_len),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_undriven   (rsp_undriven),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .jtag_TCK       (jtag_TCK),
        .jtag_TMS       (jtag_TMS),
        .jtag_TDI       (jtag_TDI),
        .jtag_TRSTn     (jtag_TRSTn),
        .jtag_TDO_data  (lb_q),
        .jtag_TDO_driven(tdo_drv)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pin-level model: the ordered list of (TMS,TDI) at each TCK rise, plus the response.
    task automatic push_edge(input bit tms, input bit tdi);
        exp_tms_q.push_back(tms);
        exp_tdi_q.push_back(tdi);
    endtask

    task automatic model_boot();
        for (int i = 0; i < 6; i++) push_edge(i < 5, 1'b0);
    endtask

    task automatic model_cmd(input logic [1:0] op, input int len, input logic [63:0] data, input bit lb);
        rsp_t        r;
        logic [63:0] mask;
        r = '0;
        if ((op == 2'd1 || op == 2'd2) && (len == 0 || len > MAX_LEN)) begin
            r.err = 1'b1;
        end else if (op == 2'd0) begin
            model_boot();
        end else if (op == 2'd3) begin
            for (int i = 0; i < len; i++) push_edge(1'b0, 1'b0);
        end else begin
            push_edge(1'b1, 1'b0);
            if (op == 2'd1) push_edge(1'b1, 1'b0);
            push_edge(1'b0, 1'b0);
            push_edge(1'b0, 1'b0);
            for (int i = 0; i < len; i++) push_edge(i == len - 1, data[i]);
            push_edge(1'b1, 1'b0);
            push_edge(1'b0, 1'b0);
            mask   = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
            r.data = lb ? ((data << 1) & mask) : 64'd0;
            r.und  = !lb;
        end
        exp_rsp_q.push_back(r);
    endtask

    // Loopback target: TDO presents the TDI seen at the previous TCK rise.
    always @(posedge jtag_TCK) lb_q = jtag_TDI;

    always @(posedge jtag_TCK) begin
        edges++;
        tms_log = {tms_log[62:0], jtag_TMS};
        tdi_log = {tdi_log[62:0], jtag_TDI};
        check("tck_edge_expected", 64'(exp_tms_q.size() > 0), 64'd1);
        if (exp_tms_q.size() > 0) begin
            check("edge_tms", 64'(jtag_TMS), 64'(exp_tms_q.pop_front()));
            check("edge_tdi", 64'(jtag_TDI), 64'(exp_tdi_q.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (rsp_valid && !prev_valid) begin
            check("rsp_expected", 64'(exp_rsp_q.size() > 0), 64'd1);
            if (exp_rsp_q.size() > 0) begin
                cur_r = exp_rsp_q.pop_front();
                check("rsp_data", rsp_data, cur_r.data);
                check("rsp_err", 64'(rsp_err), 64'(cur_r.err));
                check("rsp_undriven", 64'(rsp_undriven), 64'(cur_r.und));
            end
            last_data = rsp_data;
            last_err  = rsp_err;
            last_und  = rsp_undriven;
            rsp_seen++;
        end
        if (rsp_valid && prev_valid && !prev_ready) check("rsp_hold", rsp_data, prev_data);
        if (busy || rsp_valid) check("ready_low_busy", 64'(cmd_ready), 64'd0);
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_data  = rsp_data;
    end

    task automatic issue(input logic [1:0] op, input int len, input logic [63:0] data, input bit lb);
        model_cmd(op, len, data, lb);
        tdo_drv   = lb;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int k = 0; k < 2000 && !cmd_ready; k++) @(negedge clock);
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string name);
        for (int k = 0; k < 2000 && rsp_seen < target; k++) @(negedge clock);
        check(name, 64'(rsp_seen >= target), 64'd1);
    endtask

    task automatic wait_edges(input int target, input string name);
        for (int k = 0; k < 2000 && edges < target; k++) @(negedge clock);
        check(name, 64'(edges >= target), 64'd1);
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 2000 && !cmd_ready; k++) @(negedge clock);
        check(name, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_tck", 64'(jtag_TCK), 64'd0);
        check("rst_tms", 64'(jtag_TMS), 64'd1);
        check("rst_tdi", 64'(jtag_TDI), 64'd0);
        check("rst_trstn", 64'(jtag_TRSTn), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_flags", {62'd0, rsp_undriven, rsp_err}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Test 1: boot
        model_boot();
        e0 = edges;
        reset = 1'b0;
        init_done = 1'b1;
        wait_ready("boot_ready");
        check("boot_edges", 64'(edges - e0), 64'd6);
        check("boot_tms_seq", tms_log[5:0], 64'b111110);
        check("boot_trstn", 64'(jtag_TRSTn), 64'd1);

        // Test 2: DR scan with loopback
        e0 = edges;
        issue(2'd2, 8, 64'hA5, 1'b1);
        wait_rsp(1, "dr_rsp_timeout");
        check("dr_edges", 64'(edges - e0), 64'd13);
        check("dr_tms_seq", tms_log[12:0], 64'b1000000000110);
        check("dr_tdi_seq", tdi_log[12:0], 64'b0001010010100);
        check("dr_data", last_data, 64'h4A);
        check("dr_undriven", 64'(last_und), 64'd0);

        // Test 3: IR scan, TDO undriven
        e0 = edges;
        issue(2'd1, 5, 64'h11, 1'b0);
        wait_rsp(2, "ir_rsp_timeout");
        check("ir_edges", 64'(edges - e0), 64'd11);
        check("ir_tms_seq", tms_log[10:0], 64'b11000000110);
        check("ir_data", last_data, 64'd0);
        check("ir_undriven", 64'(last_und), 64'd1);

        // Test 4: rejected lengths and idle cycles
        e0 = edges;
        issue(2'd2, 0, 64'hFF, 1'b1);
        wait_rsp(3, "len0_rsp_timeout");
        check("len0_err", 64'(last_err), 64'd1);
        issue(2'd2, MAX_LEN + 1, 64'hFF, 1'b1);
        wait_rsp(4, "lenmax_rsp_timeout");
        check("lenmax_err", 64'(last_err), 64'd1);
        check("err_no_edges", 64'(edges - e0), 64'd0);
        issue(2'd3, 3, 64'd0, 1'b0);
        wait_rsp(5, "idle_rsp_timeout");
        check("idle_err", 64'(last_err), 64'd0);
        check("idle_edges", 64'(edges - e0), 64'd3);
        check("idle_tms", tms_log[2:0], 64'd0);

        // Test 5: response backpressure
        rsp_ready = 1'b0;
        issue(2'd2, 4, 64'h6, 1'b1);
        wait_rsp(6, "bp_rsp_timeout");
        model_cmd(2'd3, 1, 64'd0, 1'b0);
        cmd_op = 2'd3;
        cmd_len = LEN_W'(1);
        cmd_data = '0;
        cmd_valid = 1'b1;
        e0 = edges;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_data_held", rsp_data, 64'hC);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        check("bp_no_edges", 64'(edges - e0), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_valid_drop", 64'(rsp_valid), 64'd0);
        check("bp_ready_rise", 64'(cmd_ready), 64'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
        wait_rsp(7, "bp_next_timeout");

        // Test 6a: enable pause during shift bit 3
        e0 = edges;
        issue(2'd2, 8, 64'h3C, 1'b1);
        wait_edges(e0 + 6, "pause_reach_timeout");
        enable = 1'b0;
        e1 = edges;
        repeat (10) @(negedge clock);
        check("pause_no_edges", 64'(edges - e1), 64'd0);
        check("pause_busy", 64'(busy), 64'd1);
        enable = 1'b1;
        wait_rsp(8, "pause_rsp_timeout");
        check("pause_data", last_data, 64'h78);
        check("pause_edges", 64'(edges - e0), 64'd13);

        // Test 6b: reset during shift bit 2
        e0 = edges;
        issue(2'd2, 8, 64'hFF, 1'b1);
        wait_edges(e0 + 5, "rstmid_reach_timeout");
        reset = 1'b1;
        exp_tms_q.delete();
        exp_tdi_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clock);
        check("rstmid_tck", 64'(jtag_TCK), 64'd0);
        check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstmid_trstn", 64'(jtag_TRSTn), 64'd0);
        check("rstmid_tms", 64'(jtag_TMS), 64'd1);
        model_boot();
        e1 = edges;
        reset = 1'b0;
        wait_ready("reboot_ready");
        check("reboot_edges", 64'(edges - e1), 64'd6);
        check("reboot_tms_seq", tms_log[5:0], 64'b111110);
        check("no_extra_rsp", 64'(rsp_seen), 64'd8);
        repeat (4) @(negedge clock);
        check("model_drained", 64'(exp_tms_q.size() + exp_rsp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
